// File: rtl/nios2_debug_pkg.sv
// rtl/nios2_debug_pkg.sv - shared types and constants for the debug command block
package nios2_debug_pkg;

  localparam int DEF_SR_W        = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_CNT_W       = 16;

  // Action state: IDLE has no pending action, PEND holds one for the CPU
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // Sub-command select carried in jdo[SR_W-2:SR_W-3]
  localparam logic [1:0] SUB_A = 2'b00;
  localparam logic [1:0] SUB_B = 2'b01;
  localparam logic [1:0] SUB_C = 2'b10;

endpackage

// File: rtl/nios2_debug_cmd_sysclk_if.sv
// rtl/nios2_debug_cmd_sysclk_if.sv - action handshake between command block and CPU debug logic
interface nios2_debug_cmd_sysclk_if
  import nios2_debug_pkg::*;
#(
  parameter int SR_W = DEF_SR_W,
  parameter int IR_W = DEF_IR_W
);
  logic [SR_W-1:0] jdo;
  logic            act_valid;
  logic            act_ready;
  logic [IR_W-1:0] act_ir;
  logic            act_take;
  logic [1:0]      act_sub;

  modport master (
    output jdo, act_valid, act_ir, act_take, act_sub,
    input  act_ready
  );

  modport slave (
    input  jdo, act_valid, act_ir, act_take, act_sub,
    output act_ready
  );
endinterface

// File: rtl/nios2_debug_sync_edge.sv
// rtl/nios2_debug_sync_edge.sv - multi-flop synchroniser with rising-edge detector
module nios2_debug_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              edge_q, edge_d;
  // Prime chain: edges are only reported once the edge flop has followed a
  // fully refilled synchroniser, so a level held through reset is not an edge.
  logic [STAGES:0]   prime_q, prime_d;

  // Next-state: shift the input in, edge flop follows the synchronised level
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d};
    edge_d  = sync_q[STAGES-1];
    prime_d = {prime_q[STAGES-1:0], 1'b1};
  end

  // Synchroniser, edge and prime registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      prime_q <= prime_d;
    end
  end

  assign rise = prime_q[STAGES] & sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/nios2_debug_cmd_sysclk.sv
// rtl/nios2_debug_cmd_sysclk.sv - system-clock side of the JTAG debug command path
module nios2_debug_cmd_sysclk
  import nios2_debug_pkg::*;
#(
  parameter int SR_W        = DEF_SR_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IR_W-1:0]         ir_in,
  input  logic [SR_W-1:0]         sr,
  input  logic                    vs_udr,
  input  logic                    vs_uir,
  input  logic                    ovr_clr,
  output logic                    uir_pulse,
  output logic                    overrun,
  output logic [CNT_W-1:0]        cmd_count,
  nios2_debug_cmd_sysclk_if.master act_if
);

  logic udr_evt;
  logic uir_evt;

  nios2_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (vs_udr),
    .rise  (udr_evt)
  );

  nios2_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk   (clk),
    .reset (reset),
    .d     (vs_uir),
    .rise  (uir_evt)
  );

  state_e           state_q, state_d;
  logic [SR_W-1:0]  jdo_q, jdo_d;
  logic [IR_W-1:0]  act_ir_q, act_ir_d;
  logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
  logic             overrun_q, overrun_d;
  logic             uir_pulse_q, uir_pulse_d;
  logic             capture;
  logic             ovr_set;

  // Command FSM: accept, acknowledge, discard-on-overrun and IR flush
  always_comb begin
    state_d     = state_q;
    jdo_d       = jdo_q;
    act_ir_d    = act_ir_q;
    cmd_count_d = cmd_count_q;
    capture     = 1'b0;
    ovr_set     = 1'b0;
    uir_pulse_d = uir_evt;

    case (state_q)
      IDLE: begin
        if (udr_evt) begin
          capture = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (udr_evt) begin
          // A new update wins over the IR flush; it is only taken if the
          // CPU is accepting the current action in the same cycle.
          if (act_if.act_ready) begin
            capture = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (act_if.act_ready || uir_evt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      jdo_d       = sr;
      act_ir_d    = ir_in;
      cmd_count_d = cmd_count_q + CNT_W'(1);
    end

    // Setting takes priority over a coincident clear
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      jdo_q       <= '0;
      act_ir_q    <= '0;
      cmd_count_q <= '0;
      overrun_q   <= 1'b0;
      uir_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      jdo_q       <= jdo_d;
      act_ir_q    <= act_ir_d;
      cmd_count_q <= cmd_count_d;
      overrun_q   <= overrun_d;
      uir_pulse_q <= uir_pulse_d;
    end
  end

  assign act_if.jdo       = jdo_q;
  assign act_if.act_valid = (state_q == PEND);
  assign act_if.act_ir    = act_ir_q;
  assign act_if.act_take  = jdo_q[SR_W-1];
  assign act_if.act_sub   = jdo_q[SR_W-2:SR_W-3];

  assign uir_pulse = uir_pulse_q;
  assign overrun   = overrun_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk.sv
// tb/tb_nios2_debug_cmd_sysclk.sv - scoreboard bench for the debug command block
module tb_nios2_debug_cmd_sysclk;
  import nios2_debug_pkg::*;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int SYNC  = 3;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [IR_W-1:0]  ir_in;
  logic [SR_W-1:0]  sr;
  logic             vs_udr;
  logic             vs_uir;
  logic             ovr_clr;
  logic             uir_pulse;
  logic             overrun;
  logic [CNT_W-1:0] cmd_count;

  nios2_debug_cmd_sysclk_if #(.SR_W(SR_W), .IR_W(IR_W)) act_if ();

  nios2_debug_cmd_sysclk #(
    .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ir_in     (ir_in),
    .sr        (sr),
    .vs_udr    (vs_udr),
    .vs_uir    (vs_uir),
    .ovr_clr   (ovr_clr),
    .uir_pulse (uir_pulse),
    .overrun   (overrun),
    .cmd_count (cmd_count),
    .act_if    (act_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SR_W-1:0]  jdo;
    logic [IR_W-1:0]  ir;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  // Reference model of the command path
  logic             m_pend;
  logic             m_ovr;
  logic [CNT_W-1:0] m_count;
  logic [SR_W-1:0]  m_jdo;
  logic [IR_W-1:0]  m_ir;
  int               uir_exp = 0;
  int               uir_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_ovr = 1'b0; m_count = '0; m_jdo = '0; m_ir = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".act_valid"}, 64'(act_if.act_valid), 64'(m_pend));
    check({tag, ".overrun"},   64'(overrun),          64'(m_ovr));
    check({tag, ".cmd_count"}, 64'(cmd_count),        64'(m_count));
    check({tag, ".jdo"},       64'(act_if.jdo),       64'(m_jdo));
    check({tag, ".act_ir"},    64'(act_if.act_ir),    64'(m_ir));
    check({tag, ".act_take"},  64'(act_if.act_take),  64'(m_jdo[SR_W-1]));
    check({tag, ".act_sub"},   64'(act_if.act_sub),   64'(m_jdo[SR_W-2:SR_W-3]));
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[SR_W-1:0];
  endfunction

  // One update-DR with act_ready held static at r for the whole transaction
  task automatic do_udr(input logic r, input logic [SR_W-1:0] s, input logic [IR_W-1:0] i);
    logic accepted;
    exp_t e;
    act_if.act_ready = r;
    cyc(2);
    if (r) m_pend = 1'b0;
    accepted = !m_pend;
    if (accepted) begin
      m_count = m_count + 1'b1;
      m_jdo = s; m_ir = i;
      e.jdo = s; e.ir = i; e.cnt = m_count;
      exp_q.push_back(e);
      m_pend = !r;
    end else begin
      m_ovr = 1'b1;
    end
    sr = s; ir_in = i; vs_udr = 1'b1;
    cyc(6);
    vs_udr = 1'b0;
    cyc(6);
    act_if.act_ready = 1'b0;
    cyc(1);
  endtask

  task automatic do_uir();
    act_if.act_ready = 1'b0;
    vs_uir = 1'b1;
    cyc(6);
    vs_uir = 1'b0;
    cyc(6);
    m_pend = 1'b0;
    uir_exp++;
  endtask

  task automatic do_clr();
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    cyc(1);
    m_ovr = 1'b0;
  endtask

  // Monitor: every change of cmd_count is an accepted command to score
  logic [CNT_W-1:0] prev_count = '0;
  logic             prev_uir = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_count = '0;
      prev_uir   = 1'b0;
    end else begin
      if (cmd_count != prev_count) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got count %0h with no expected command", cmd_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb.jdo",       64'(act_if.jdo),       64'(e.jdo));
          check("sb.act_ir",    64'(act_if.act_ir),    64'(e.ir));
          check("sb.cmd_count", 64'(cmd_count),        64'(e.cnt));
          check("sb.act_valid", 64'(act_if.act_valid), 64'd1);
        end
        prev_count = cmd_count;
      end
      if (uir_pulse) begin
        uir_seen++;
        check("uir_pulse_width", 64'(prev_uir), 64'd0);
      end
      prev_uir = uir_pulse;
    end
  end

  initial begin
    exp_t e;
    reset = 1'b1; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0; ovr_clr = 1'b0;
    act_if.act_ready = 1'b0;
    model_reset();
    cyc(3);
    check_state("reset");
    check("reset.uir_pulse", 64'(uir_pulse), 64'd0);
    reset = 1'b0;
    cyc(10);

    // First command: latency of SYNC_STAGES+1 cycles
    e.jdo = 38'h2_0000_0001; e.ir = 2'd2; e.cnt = 4'd1;
    exp_q.push_back(e);
    sr = 38'h2_0000_0001; ir_in = 2'd2; vs_udr = 1'b1;
    cyc(SYNC);
    check("latency.early", 64'(act_if.act_valid), 64'd0);
    cyc(1);
    m_pend = 1'b1; m_count = 4'd1; m_jdo = 38'h2_0000_0001; m_ir = 2'd2;
    check_state("first");
    check("first.sub_a", 64'(act_if.act_sub), 64'(SUB_A));
    cyc(2);
    vs_udr = 1'b0;
    cyc(6);

    // Overrun on update while pending, then clear
    do_udr(1'b0, 38'h1, 2'd1);
    check_state("overrun");
    do_clr();
    check_state("ovr_clr");

    // Acknowledge coinciding with the update keeps PEND and captures
    sr = rand_sr(); ir_in = 2'd3; vs_udr = 1'b1;
    e.jdo = sr; e.ir = 2'd3; e.cnt = m_count + 1'b1;
    exp_q.push_back(e);
    cyc(SYNC);
    act_if.act_ready = 1'b1;
    cyc(1);
    act_if.act_ready = 1'b0;
    m_count = m_count + 1'b1; m_jdo = e.jdo; m_ir = 2'd3; m_pend = 1'b1;
    check_state("ack_coincide");
    cyc(2);
    vs_udr = 1'b0;
    cyc(6);

    // IR update flushes the pending action
    do_uir();
    check_state("uir_flush");

    // Coincident DR and IR updates while pending: overrun, no flush
    do_udr(1'b0, rand_sr(), 2'd0);
    vs_udr = 1'b1; vs_uir = 1'b1; sr = rand_sr();
    cyc(6);
    vs_udr = 1'b0; vs_uir = 1'b0;
    cyc(6);
    m_ovr = 1'b1;
    uir_exp++;
    check_state("udr_uir");
    do_clr();

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op <= 5) do_udr(1'($urandom_range(0, 1)), rand_sr(), 2'($urandom_range(0, 3)));
      else if (op == 6) do_uir();
      else do_clr();
      check_state("rand");
    end

    // Asynchronous reset while pending with overrun set
    do_udr(1'b0, rand_sr(), 2'd1);
    do_udr(1'b0, rand_sr(), 2'd2);
    check("pre_reset.overrun", 64'(overrun), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_state("async_reset");

    // Update level held through reset release is not an event
    vs_udr = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(20);
    check_state("udr_held");
    vs_udr = 1'b0;
    cyc(8);

    // 2^CNT_W accepted commands wrap the counter to zero
    for (int n = 0; n < (1 << CNT_W); n++) begin
      do_udr(1'b1, rand_sr(), 2'($urandom_range(0, 3)));
    end
    check_state("wrap");
    check("wrap.zero", 64'(cmd_count), 64'd0);

    cyc(4);
    check("sb.drained", 64'(exp_q.size()), 64'd0);
    check("uir_count", 64'(uir_seen), 64'(uir_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
